// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared FSM states, access-size encodings and byte-lane helpers for the data memory.
package arm_mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;
  localparam int LANES = 4;
  localparam int LANE_W = 8;
  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction
  function automatic logic [LANE_W-1:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    return word[lane*LANE_W +: LANE_W];
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 storage, byte-enabled synchronous write, asynchronous word read.
module dmem_array import arm_mem_pkg::*; #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [LANES-1:0]         be,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < LANES; i++)
      if (be[i]) mem[idx][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
  assign rdata = mem[idx];
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: wait-state data-memory controller with word/byte access, misalignment flag and core stall.
module dmem_ctrl import arm_mem_pkg::*; #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic              size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd,
  output logic              ready,
  output logic              err,
  output logic              stall
);
  localparam int IW = $clog2(DEPTH);
  if (DATA_W != 32) begin : g_bad_data_w
    $error("dmem_ctrl: DATA_W must be 32");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dmem_ctrl: DEPTH must be a power of two >= 2");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_ctrl: WAIT_CYCLES must be 0..15");
  end
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic we_q, size_q;
  logic [IW+1:0] addr_q;
  logic [DATA_W-1:0] wd_q;
  logic idle, c_we, c_size, mis;
  logic [IW+1:0] c_addr;
  logic [LANES-1:0] be;
  logic [31:0] word, wdata;
  logic unused_addr;
  assign unused_addr = ^addr[ADDR_W-1:IW+2];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: if (req) begin
        cnt_n   = 4'(WAIT_CYCLES);
        state_n = WAIT_CYCLES == 0 ? RESP : BUSY;
      end
      BUSY: begin
        cnt_n   = cnt - 4'd1;
        state_n = cnt <= 4'd1 ? RESP : BUSY;
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      we_q   <= 1'b0;
      size_q <= SIZE_WORD;
      addr_q <= '0;
      wd_q   <= '0;
    end else if (state == IDLE && req) begin
      we_q   <= we;
      size_q <= size;
      addr_q <= addr[IW+1:0];
      wd_q   <= wd;
    end
  // In IDLE the live request is used so a zero-wait load can capture rd on the accepting edge.
  assign idle   = state == IDLE;
  assign c_we   = idle ? we : we_q;
  assign c_size = idle ? size : size_q;
  assign c_addr = idle ? addr[IW+1:0] : addr_q;
  assign mis    = c_size == SIZE_WORD && c_addr[1:0] != 2'b00;
  assign be     = (state == RESP && c_we && !mis) ? (c_size == SIZE_BYTE ? lane_mask(c_addr[1:0]) : 4'hF) : 4'h0;
  assign wdata  = c_size == SIZE_BYTE ? {LANES{wd_q[7:0]}} : wd_q;
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .idx   (c_addr[IW+1:2]),
    .be    (be),
    .wdata (wdata),
    .rdata (word)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) rd <= '0;
    else if (state != RESP && state_n == RESP && !c_we && !mis)
      rd <= c_size == SIZE_BYTE ? {24'b0, lane_byte(word, c_addr[1:0])} : word;
  assign ready = state == RESP;
  assign err   = ready && mis;
  assign stall = req && state != RESP;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized and directed checks of dmem_ctrl (WAIT_CYCLES 0 and 2) against a memory model.
module tb_dmem_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic req [2], we [2], size [2], ready [2], err [2], stall [2];
  logic [31:0] addr [2], wd [2], rd [2];
  logic [31:0] mem_m [2][64];
  logic [31:0] rd_m [2];
  logic [31:0] last_rd;
  logic last_err;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .size(size[0]), .addr(addr[0]),
    .wd(wd[0]), .rd(rd[0]), .ready(ready[0]), .err(err[0]), .stall(stall[0]));
  dmem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .size(size[1]), .addr(addr[1]),
    .wd(wd[1]), .rd(rd[1]), .ready(ready[1]), .err(err[1]), .stall(stall[1]));

  task automatic access(input int d, input logic w, input logic s, input logic [31:0] a, input logic [31:0] data);
    int n, st, wt, idx, lane;
    logic done, m;
    logic [31:0] exp_rd;
    wt   = d == 0 ? 0 : 2;
    idx  = (a / 4) % 64;
    lane = a % 4;
    m    = !s && lane != 0;
    exp_rd = rd_m[d];
    if (!w && !m) exp_rd = s ? (mem_m[d][idx] >> (8 * lane)) & 32'hFF : mem_m[d][idx];
    @(negedge clk);
    we[d] = w; size[d] = s; addr[d] = a; wd[d] = data; req[d] = 1'b1;
    n = 0; st = 0; done = 1'b0;
    while (!done && n < 40) begin
      #1;
      n++;
      if (stall[d]) st++;
      if (ready[d]) done = 1'b1;
      else @(negedge clk);
    end
    last_rd = rd[d];
    last_err = err[d];
    req[d] = 1'b0;
    tests++;
    if (!done) begin fails++; $display("FAIL ready_timeout dut%0d addr=%h: no ready within 40 cycles", d, a); end
    tests++;
    if (n !== wt + 2) begin fails++; $display("FAIL latency dut%0d addr=%h: got %0d cycles, want %0d", d, a, n, wt + 2); end
    tests++;
    if (st !== wt + 1) begin fails++; $display("FAIL stall_cycles dut%0d addr=%h: got %0d, want %0d", d, a, st, wt + 1); end
    tests++;
    if (last_err !== m) begin fails++; $display("FAIL err dut%0d addr=%h size=%0d: got %b, want %b", d, a, s, last_err, m); end
    tests++;
    if (last_rd !== exp_rd) begin fails++; $display("FAIL rd dut%0d addr=%h we=%0d size=%0d: got %h, want %h", d, a, w, s, last_rd, exp_rd); end
    rd_m[d] = exp_rd;
    if (w && !m) begin
      if (s) mem_m[d][idx][lane*8 +: 8] = data[7:0];
      else mem_m[d][idx] = data;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; size[d] = 1'b0; addr[d] = '0; wd[d] = '0; rd_m[d] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (rd[d] !== 32'h0 || ready[d] !== 1'b0 || err[d] !== 1'b0 || stall[d] !== 1'b0) begin
        fails++;
        $display("FAIL reset_state dut%0d: rd=%h ready=%b err=%b stall=%b, want 0", d, rd[d], ready[d], err[d], stall[d]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_fill;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) access(d, 1'b1, 1'b0, 32'(i * 4), $urandom);
  endtask

  task automatic test_word_store_load;
    access(1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    access(1, 1'b0, 1'b0, 32'h10, 32'h0);
    tests++;
    if (last_rd !== 32'hDEADBEEF) begin fails++; $display("FAIL word_load: got %h, want deadbeef", last_rd); end
  endtask

  task automatic test_byte;
    access(1, 1'b1, 1'b0, 32'h10, 32'h11223344);
    access(1, 1'b1, 1'b1, 32'h13, 32'h5A5A5AAA);
    access(1, 1'b0, 1'b0, 32'h10, 32'h0);
    tests++;
    if (last_rd !== 32'hAA223344) begin fails++; $display("FAIL strb_word_load: got %h, want aa223344", last_rd); end
    access(1, 1'b0, 1'b1, 32'h11, 32'h0);
    tests++;
    if (last_rd !== 32'h00000033) begin fails++; $display("FAIL ldrb: got %h, want 00000033", last_rd); end
  endtask

  task automatic test_misaligned;
    access(1, 1'b1, 1'b0, 32'h20, 32'h0BADF00D);
    access(1, 1'b1, 1'b0, 32'h22, 32'hFFFFFFFF);
    tests++;
    if (last_err !== 1'b1) begin fails++; $display("FAIL misaligned_err: got %b, want 1", last_err); end
    access(1, 1'b0, 1'b0, 32'h20, 32'h0);
    tests++;
    if (last_rd !== 32'h0BADF00D) begin fails++; $display("FAIL misaligned_no_write: got %h, want 0badf00d", last_rd); end
    access(1, 1'b0, 1'b0, 32'h21, 32'h0);
    tests++;
    if (last_rd !== 32'h0BADF00D) begin fails++; $display("FAIL misaligned_load_keeps_rd: got %h, want 0badf00d", last_rd); end
  endtask

  task automatic test_wrap;
    access(1, 1'b1, 1'b0, 32'h104, 32'h5);
    access(1, 1'b0, 1'b0, 32'h004, 32'h0);
    tests++;
    if (last_rd !== 32'h5) begin fails++; $display("FAIL addr_wrap: got %h, want 00000005", last_rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a;
    logic exp_ready;
    a = 32'h0;
    @(negedge clk);
    we[0] = 1'b0; size[0] = 1'b0; addr[0] = a; req[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_ready = k % 2 == 1;
      tests++;
      if (ready[0] !== exp_ready || stall[0] !== !exp_ready) begin
        fails++;
        $display("FAIL b2b_cycle%0d: ready=%b stall=%b, want ready=%b stall=%b", k, ready[0], stall[0], exp_ready, !exp_ready);
      end
      if (exp_ready) begin
        rd_m[0] = mem_m[0][(a / 4) % 64];
        tests++;
        if (rd[0] !== rd_m[0]) begin fails++; $display("FAIL b2b_rd addr=%h: got %h, want %h", a, rd[0], rd_m[0]); end
        a = a + 32'h4C;
        addr[0] = a;
      end
      @(negedge clk);
    end
    req[0] = 1'b0;
  endtask

  task automatic test_reset_mid_store;
    logic [31:0] old;
    old = mem_m[1][2];
    @(negedge clk);
    we[1] = 1'b1; size[1] = 1'b0; addr[1] = 32'h08; wd[1] = 32'h1234; req[1] = 1'b1;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (rd[d] !== 32'h0 || err[d] !== 1'b0 || ready[d] !== 1'b0) begin
        fails++;
        $display("FAIL reset_abort_state dut%0d: rd=%h err=%b ready=%b, want 0", d, rd[d], err[d], ready[d]);
      end
      rd_m[d] = '0;
    end
    req[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++;
      if (ready[1] !== 1'b0) begin fails++; $display("FAIL reset_no_ready cycle%0d: got %b, want 0", k, ready[1]); end
      @(negedge clk);
    end
    access(1, 1'b0, 1'b0, 32'h08, 32'h0);
    tests++;
    if (last_rd !== old) begin fails++; $display("FAIL reset_no_write: got %h, want %h", last_rd, old); end
  endtask

  task automatic test_random;
    logic w, s;
    logic [31:0] a;
    for (int i = 0; i < 80; i++) begin
      w = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 1023));
      if (!s && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      access(i % 4 == 0 ? 0 : 1, w, s, a, $urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_fill;
    test_word_store_load;
    test_byte;
    test_misaligned;
    test_wrap;
    test_back_to_back;
    test_reset_mid_store;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data-memory controller replacing the zero-latency data memory beside the `arm` core in the single-cycle top level. It accepts one load/store request at a time and inserts a configurable number of wait states. It supports word and byte (LDRB/STRB) accesses and flags misaligned word accesses. It drives a `stall` back to the core so the processor can run against slower memory.

## Interface
- `DATA_W`, default 32: data width in bits; must be 32 (byte lanes fixed at 4).
- `ADDR_W`, default 32: byte-address width.
- `DEPTH`, default 64: memory depth in words; power of two, at least 2.
- `WAIT_CYCLES`, default 1: wait states per access; legal range 0..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  access request; held high by the core while `stall` is high.
- `we`  in  1  1 = store, 0 = load; sampled with `req`.
- `size`  in  1  0 = word, 1 = byte.
- `addr`  in  ADDR_W  byte address.
- `wd`  in  DATA_W  store data; byte stores use `wd[7:0]`.
- `rd`  out  DATA_W  load data; registered and held until the next load completes.
- `ready`  out  1  one-cycle completion pulse.
- `err`  out  1  misaligned word access; pulses together with `ready`.
- `stall`  out  1  combinational: `req` high and state is not RESP.

## Operation
- FSM has three states: IDLE, BUSY, RESP.
- **IDLE**
  - On `req`: latch `we`, `size`, `addr`, `wd`; load the wait counter with `WAIT_CYCLES`.
  - Next state is BUSY, or RESP directly if `WAIT_CYCLES` = 0.
  - Without `req`, stay in IDLE.
- **BUSY**
  - Decrement the counter each cycle.
  - When the counter reaches 1, move to RESP on the next edge.
  - `req`, `addr` and the other request inputs are ignored; only latched values are used.
- **RESP**
  - Assert `ready` for exactly one cycle.
  - Store: the write commits to the array at the edge that leaves RESP.
  - Load: `rd` is updated on entry to RESP.
  - Always return to IDLE.
- Word index is `addr[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- **Byte load:** lane `addr[1:0]`, little-endian (lane 0 = bits 7:0), zero-extended into `rd`.
- **Byte store:** writes only lane `addr[1:0]`; the other three bytes are unchanged.
- **Misaligned word access** (`size` = 0, `addr[1:0]` ≠ 0):
  - `err` = 1 with `ready`.
  - A store writes nothing.
  - A load leaves `rd` unchanged.
- Reset values: state IDLE, counter 0, `ready` 0, `err` 0, `rd` 0. Memory contents are not reset.
- Reset asserted mid-access aborts the access: no write, no `ready` pulse.

## Timing
- Latency from the accepting IDLE edge to the `ready` pulse is `WAIT_CYCLES` + 1 cycles.
- Throughput is one access per `WAIT_CYCLES` + 2 cycles, because RESP→IDLE adds a cycle before the next `req` is sampled.
- `stall` is high from the cycle `req` rises in IDLE through the last BUSY cycle, and low in RESP. The core therefore advances its PC at the edge ending RESP.
- A `req` still high in the IDLE cycle after RESP is treated as a new access; the core must update `req` with its next instruction.
- `rd` is valid in the `ready` cycle and stable until the next successful load's RESP.
- There is no combinational path from `addr` or `wd` to `rd`, `ready` or `err`. `stall` depends combinationally on `req` and state only.

## Structure
- Shared package `arm_mem_pkg` holds:
  - the state enum (IDLE, BUSY, RESP);
  - the size encodings SIZE_WORD = 0 and SIZE_BYTE = 1;
  - the lane-select helper constants.
- Sub-module `dmem_array`: DEPTH×32 storage with a 4-bit byte-write-enable synchronous write and an asynchronous word read. `dmem_ctrl` owns the FSM, counter, lane muxing and error logic.
- Parameter checks (`DATA_W` = 32, DEPTH a power of two, `WAIT_CYCLES` ≤ 15) are elaboration-time assertions.

## Test plan
- **Word store/load, WAIT_CYCLES = 2:**
  - store `0xDEADBEEF` at 0x10, then load 0x10 → `ready` 3 cycles after acceptance, `rd` = `0xDEADBEEF`;
  - `stall` high for exactly 3 cycles per access.
- **Byte store, then word load:** STRB `0xAA` at 0x13 over word `0x11223344` → word read returns `0xAA223344`; LDRB 0x11 → `rd` = `0x00000033`.
- **Misaligned word store** at 0x22 with `wd` = `0xFFFFFFFF` → `err` = 1 with `ready`; a word load of 0x20 returns the prior contents unchanged.
- **WAIT_CYCLES = 0 back-to-back loads** with `req` held → one `ready` every 2 cycles; `stall` is high in IDLE and low in RESP.
- **Address wrap, DEPTH = 64:** store `0x5` at 0x104 → load 0x004 returns `0x5`.
- **Reset during BUSY of a store** of `0x1234` to 0x08 → no `ready`; after reset, load 0x08 returns the old value; `rd` = 0 and `err` = 0 immediately after reset.
